// File: rtl/commutator_transpose_if.sv
// Stream bundle for the corner-turn commutator: row beats in, column beats out.
interface commutator_transpose_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int IDX_W  = $clog2(LANES)
);
    logic                    in_valid;
    logic                    in_sof;
    logic                    in_bypass;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_sof;
    logic [IDX_W-1:0]        out_idx;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    err_drop;

    modport master (
        output in_valid, in_sof, in_bypass, in_data,
        input  out_valid, out_sof, out_idx, out_data, err_drop
    );

    modport slave (
        input  in_valid, in_sof, in_bypass, in_data,
        output out_valid, out_sof, out_idx, out_data, err_drop
    );
endinterface

// File: rtl/commutator_transpose.sv
// LANES x LANES corner-turn between radix-LANES butterfly stages; ping-pong banks,
// rows written in, columns (or rows, in bypass) read out one beat per cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no readout in progress, out_valid low
// ST_READ | a column beat is on the outputs; out_idx is its column
module commutator_transpose #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  reset,
    commutator_transpose_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_READ} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    logic [DATA_W-1:0] mem_q [2][LANES][LANES];
    logic [DATA_W-1:0] mem_d [2][LANES][LANES];
    logic [DATA_W-1:0] blk   [LANES][LANES];

    logic [IDX_W-1:0]        wr_row_q, wr_row_d, row;
    logic                    wr_bank_q, wr_bank_d;
    logic                    byp_q, byp_d;
    logic                    rd_bank_q, rd_bank_d;
    logic                    rd_byp_q, rd_byp_d;
    state_t                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sof_q, out_sof_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;
    logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
    logic                    err_drop_q, err_drop_d;
    logic                    launch, start, sel_byp;

    // Write side: an in_sof on a non-zero row restarts the block in the same bank.
    always_comb begin
        mem_d      = mem_q;
        wr_row_d   = wr_row_q;
        wr_bank_d  = wr_bank_q;
        byp_d      = byp_q;
        err_drop_d = 1'b0;
        launch     = 1'b0;
        row        = wr_row_q;
        if (bus.in_valid) begin
            if (bus.in_sof && (wr_row_q != '0)) begin
                err_drop_d = 1'b1;
                row        = '0;
            end
            for (int j = 0; j < LANES; j++) begin
                mem_d[wr_bank_q][row][j] = bus.in_data[j*DATA_W +: DATA_W];
            end
            if (row == '0) begin
                byp_d = bus.in_bypass;
            end
            if (row == LAST) begin
                wr_row_d  = '0;
                wr_bank_d = ~wr_bank_q;
                launch    = 1'b1;
            end else begin
                wr_row_d = row + 1'b1;
            end
        end
    end

    // Read side: column 0 of a fresh block comes from mem_d so the last row,
    // written on this same edge, is already visible to the first output beat.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_byp_d    = rd_byp_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_idx_d   = '0;
        out_data_d  = out_data_q;
        start       = 1'b0;
        if (launch) begin
            state_d     = ST_READ;
            rd_bank_d   = wr_bank_q;
            rd_byp_d    = byp_q;
            start       = 1'b1;
            out_valid_d = 1'b1;
            out_sof_d   = 1'b1;
        end else if ((state_q == ST_READ) && (out_idx_q != LAST)) begin
            out_valid_d = 1'b1;
            out_idx_d   = out_idx_q + 1'b1;
        end else begin
            state_d = ST_IDLE;
        end

        blk     = start ? mem_d[wr_bank_q] : mem_q[rd_bank_q];
        sel_byp = start ? byp_q : rd_byp_q;
        if (out_valid_d) begin
            for (int r = 0; r < LANES; r++) begin
                out_data_d[r*DATA_W +: DATA_W] = sel_byp ? blk[out_idx_d][r]
                                                         : blk[r][out_idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_row_q    <= '0;
            wr_bank_q   <= 1'b0;
            byp_q       <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_byp_q    <= 1'b0;
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            wr_row_q    <= wr_row_d;
            wr_bank_q   <= wr_bank_d;
            byp_q       <= byp_d;
            rd_bank_q   <= rd_bank_d;
            rd_byp_q    <= rd_byp_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            err_drop_q  <= err_drop_d;
        end
    end

    // Sample storage needs no reset: the reader never looks at a bank it has not launched.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.err_drop  = err_drop_q;
endmodule

// File: tb/tb_commutator_transpose.sv
// Directed bench for commutator_transpose (LANES=4, DATA_W=32): cycle-exact expected beats.
module tb_commutator_transpose;
    typedef struct {
        int           cyc;
        logic [127:0] data;
        int           idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   err_cyc = -1;
    int   rst_cyc = -1;
    bit   mon_en = 1'b0;
    logic [127:0] last_data = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    commutator_transpose_if #(.DATA_W(32), .LANES(4)) bus ();

    commutator_transpose #(.DATA_W(32), .LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid  = 1'b0;
            bus.in_sof    = 1'b0;
            bus.in_bypass = 1'b1;
            bus.in_data   = {4{32'hDEAD_BEEF}};
            step();
        end
    endtask

    task automatic put_row(input int base, input int r, input bit sof, input bit byp);
        bus.in_valid  = 1'b1;
        bus.in_sof    = sof;
        bus.in_bypass = byp;
        for (int j = 0; j < 4; j++) bus.in_data[j*32 +: 32] = 32'(base + 4*r + j);
        step();
    endtask

    // Rows r lane j = base+4r+j; non-zero rows carry the opposite bypass to prove it is ignored.
    task automatic send_block(input int base, input bit byp, input bit sof, input int gap);
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            if (r == 3) begin
                for (int k = 0; k < 4; k++) begin
                    e.cyc = cyc + 1 + k;
                    e.idx = k;
                    for (int j = 0; j < 4; j++)
                        e.data[j*32 +: 32] = byp ? 32'(base + 4*k + j) : 32'(base + 4*j + k);
                    exp_q.push_back(e);
                end
            end
            put_row(base, r, sof && (r == 0), (r == 0) ? byp : !byp);
            if (r == 1) idle(gap);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc == rst_cyc) last_data = '0;
            chk("err_drop", 128'(bus.err_drop), 128'(cyc == err_cyc));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("valid", 128'(bus.out_valid), 128'(1));
                chk("idx", 128'(bus.out_idx), 128'(mon_e.idx));
                chk("sof", 128'(bus.out_sof), 128'(mon_e.idx == 0));
                chk("data", bus.out_data, mon_e.data);
                last_data = mon_e.data;
            end else begin
                chk("idle_valid", 128'(bus.out_valid), 128'(0));
                chk("idle_idx", 128'(bus.out_idx), 128'(0));
                chk("idle_sof", 128'(bus.out_sof), 128'(0));
                chk("hold_data", bus.out_data, last_data);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_bypass = 1'b0;
        bus.in_data   = '0;
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        idle(3);

        // single transposed block
        send_block(0, 1'b0, 1'b1, 0);
        idle(6);

        // three back-to-back blocks, the third with negative samples
        send_block(0, 1'b0, 1'b1, 0);
        send_block(16, 1'b0, 1'b1, 0);
        send_block(-100, 1'b0, 1'b1, 0);
        idle(6);

        // input gap of three cycles after row 1
        send_block(0, 1'b0, 1'b1, 3);
        idle(6);

        // bypass block followed by a transposed block
        send_block(0, 1'b1, 1'b1, 0);
        send_block(16, 1'b0, 1'b1, 0);
        idle(6);

        // partial block dropped by an early sof
        put_row(200, 0, 1'b1, 1'b1);
        put_row(200, 1, 1'b0, 1'b0);
        err_cyc = cyc + 1;
        send_block(48, 1'b0, 1'b1, 0);
        idle(6);

        // reset during readout, after beat 1 is on the outputs
        send_block(64, 1'b0, 1'b1, 0);
        idle(1);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
        rst_cyc = cyc + 1;
        step();
        reset = 1'b0;
        idle(2);
        send_block(80, 1'b0, 1'b0, 0);
        idle(8);

        chk("drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
